// File: rtl/threshold_ctrl.sv
// threshold_ctrl: per-frame mean luminance and binarizer thresholds.
// Accumulate over a frame, divide at vsync rise, update thresholds.
module threshold_ctrl #(
  parameter int SUM_W = 27,
  parameter int CNT_W = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ycbcr_vsync,
  input  logic       ycbcr_de,
  input  logic [7:0] luminance,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] my_threshold_up,
  output logic [7:0] my_threshold_down,
  output logic [7:0] frame_mean,
  output logic       mean_valid,
  output logic       busy
);

  localparam int STEP_W = $clog2(SUM_W + 1);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(SUM_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t state;

  logic             vsync_q;
  logic             frame_end;
  logic             accept;

  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W:0]   sum_add;
  logic [SUM_W-1:0] sum_inc;
  logic [CNT_W-1:0] cnt_inc;

  logic [7:0]       man_up;
  logic [7:0]       man_down;
  logic [7:0]       margin;
  logic             mode;
  logic [7:0]       sh_up;
  logic [7:0]       sh_down;
  logic [7:0]       sh_margin;
  logic             sh_mode;

  logic [SUM_W-1:0] dvd;
  logic [CNT_W-1:0] dvs;
  logic [CNT_W-1:0] rem;
  logic [STEP_W-1:0] step;
  logic             empty;

  logic [CNT_W:0]   rem_sh;
  logic             ge;
  logic [CNT_W-1:0] diff;
  logic [CNT_W-1:0] rem_nx;

  logic [7:0]       q8;
  logic [7:0]       mean_src;
  logic [8:0]       up9;
  logic [7:0]       up_nx;
  logic [7:0]       down_nx;

  assign frame_end = ycbcr_vsync & ~vsync_q;
  assign accept    = frame_end & (state == IDLE);

  assign sum_add = {1'b0, sum} + {{(SUM_W - 7){1'b0}}, luminance};
  assign sum_inc = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  // One restoring-division step; dvd shifts out dividend, shifts in quotient
  always_comb begin
    rem_sh = {rem, dvd[SUM_W-1]};
    ge     = (rem_sh >= {1'b0, dvs});
    diff   = rem_sh[CNT_W-1:0] - dvs;
    rem_nx = ge ? diff : rem_sh[CNT_W-1:0];
  end

  // Saturated mean and the thresholds it implies
  always_comb begin
    q8       = (|dvd[SUM_W-1:8]) ? 8'hff : dvd[7:0];
    mean_src = empty ? frame_mean : q8;
    up9      = {1'b0, mean_src} + {1'b0, sh_margin};
    up_nx    = sh_up;
    down_nx  = sh_down;
    if (sh_mode) begin
      up_nx   = up9[8] ? 8'hff : up9[7:0];
      down_nx = (mean_src >= sh_margin) ? mean_src - sh_margin : 8'd0;
    end
  end

  // Vsync edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_q <= 1'b0;
    else        vsync_q <= ycbcr_vsync;
  end

  // Pixel accumulators; a frame end restarts them with the current pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
    end else if (frame_end) begin
      sum <= ycbcr_de ? {{(SUM_W - 8){1'b0}}, luminance} : '0;
      cnt <= ycbcr_de ? CNT_W'(1) : '0;
    end else if (ycbcr_de) begin
      sum <= sum_inc;
      cnt <= cnt_inc;
    end
  end

  // Live config registers and their frame-end shadows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      man_up    <= 8'd255;
      man_down  <= 8'd128;
      margin    <= 8'd40;
      mode      <= 1'b0;
      sh_up     <= 8'd255;
      sh_down   <= 8'd128;
      sh_margin <= 8'd40;
      sh_mode   <= 1'b0;
    end else begin
      if (cfg_wr) begin
        unique case (cfg_addr)
          2'd0: man_up   <= cfg_wdata;
          2'd1: man_down <= cfg_wdata;
          2'd2: margin   <= cfg_wdata;
          2'd3: mode     <= cfg_wdata[0];
        endcase
      end
      if (accept) begin
        sh_up     <= (cfg_wr && cfg_addr == 2'd0) ? cfg_wdata : man_up;
        sh_down   <= (cfg_wr && cfg_addr == 2'd1) ? cfg_wdata : man_down;
        sh_margin <= (cfg_wr && cfg_addr == 2'd2) ? cfg_wdata : margin;
        sh_mode   <= (cfg_wr && cfg_addr == 2'd3) ? cfg_wdata[0] : mode;
      end
    end
  end

  // Control FSM with divider datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      busy              <= 1'b0;
      mean_valid        <= 1'b0;
      frame_mean        <= 8'd0;
      my_threshold_up   <= 8'd255;
      my_threshold_down <= 8'd128;
      dvd               <= '0;
      dvs               <= '0;
      rem               <= '0;
      step              <= '0;
      empty             <= 1'b0;
    end else begin
      mean_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_end) begin
            dvd   <= sum;
            dvs   <= cnt;
            rem   <= '0;
            step  <= '0;
            empty <= (cnt == '0);
            busy  <= 1'b1;
            state <= (cnt == '0) ? UPDATE : DIVIDE;
          end
        end
        DIVIDE: begin
          dvd  <= {dvd[SUM_W-2:0], ge};
          rem  <= rem_nx;
          step <= step + STEP_W'(1);
          if (step == LAST) state <= UPDATE;
        end
        UPDATE: begin
          if (!empty) begin
            frame_mean <= q8;
            mean_valid <= 1'b1;
          end
          my_threshold_up   <= up_nx;
          my_threshold_down <= down_nx;
          busy              <= 1'b0;
          state             <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_threshold_ctrl.sv
// tb_threshold_ctrl: directed frames with hand-computed
// means, thresholds, pulse counts and reset behaviour.
module tb_threshold_ctrl;

  localparam int SUM_W = 27;
  localparam int CNT_W = 19;

  logic       clk;
  logic       rst_n;
  logic       ycbcr_vsync;
  logic       ycbcr_de;
  logic [7:0] luminance;
  logic       cfg_wr;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] my_threshold_up;
  logic [7:0] my_threshold_down;
  logic [7:0] frame_mean;
  logic       mean_valid;
  logic       busy;

  int checks;
  int failures;
  int mv_cnt;
  int mv_ref;

  threshold_ctrl #(.SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ycbcr_vsync      (ycbcr_vsync),
    .ycbcr_de         (ycbcr_de),
    .luminance        (luminance),
    .cfg_wr           (cfg_wr),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata),
    .my_threshold_up  (my_threshold_up),
    .my_threshold_down(my_threshold_down),
    .frame_mean       (frame_mean),
    .mean_valid       (mean_valid),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mean_valid) mv_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_wr    = 1'b0;
  endtask

  task automatic pixels(input int n, input logic [7:0] y);
    ycbcr_vsync = 1'b0;
    for (int i = 0; i < n; i++) begin
      ycbcr_de  = 1'b1;
      luminance = y;
      tick();
    end
    ycbcr_de = 1'b0;
  endtask

  task automatic rise();
    ycbcr_de    = 1'b0;
    ycbcr_vsync = 1'b0;
    tick();
    ycbcr_vsync = 1'b1;
    tick();
  endtask

  task automatic wait_update(input string tag);
    repeat (SUM_W) tick();
    check({tag, "_mv_pre"}, int'(mean_valid), 0);
    tick();
    check({tag, "_mv"}, int'(mean_valid), 1);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    mv_cnt      = 0;
    rst_n       = 1'b0;
    ycbcr_vsync = 1'b0;
    ycbcr_de    = 1'b0;
    luminance   = 8'd0;
    cfg_wr      = 1'b0;
    cfg_addr    = 2'd0;
    cfg_wdata   = 8'd0;
    repeat (3) tick();
    check("rst_up", int'(my_threshold_up), 255);
    check("rst_down", int'(my_threshold_down), 128);
    check("rst_mean", int'(frame_mean), 0);
    check("rst_mv", int'(mean_valid), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    cfg_write(2'd3, 8'd1);
    mv_ref = mv_cnt;
    pixels(64, 8'd100);
    rise();
    check("a100_busy", int'(busy), 1);
    repeat (SUM_W) tick();
    check("a100_mv_pre", int'(mean_valid), 0);
    check("a100_up_hold", int'(my_threshold_up), 255);
    check("a100_busy_div", int'(busy), 1);
    tick();
    check("a100_mv", int'(mean_valid), 1);
    check("a100_mean", int'(frame_mean), 100);
    check("a100_up", int'(my_threshold_up), 140);
    check("a100_down", int'(my_threshold_down), 60);
    tick();
    check("a100_mv_off", int'(mean_valid), 0);
    check("a100_busy_off", int'(busy), 0);
    check("a100_pulses", mv_cnt - mv_ref, 1);

    pixels(10, 8'd250);
    rise();
    wait_update("a250");
    check("a250_mean", int'(frame_mean), 250);
    check("a250_up", int'(my_threshold_up), 255);
    check("a250_down", int'(my_threshold_down), 210);

    pixels(10, 8'd10);
    rise();
    wait_update("a10");
    check("a10_mean", int'(frame_mean), 10);
    check("a10_up", int'(my_threshold_up), 50);
    check("a10_down", int'(my_threshold_down), 0);

    cfg_write(2'd3, 8'd0);
    pixels(4, 8'd60);
    rise();
    wait_update("m60");
    check("m60_up", int'(my_threshold_up), 255);
    check("m60_down", int'(my_threshold_down), 128);

    pixels(3, 8'd60);
    cfg_write(2'd0, 8'd200);
    check("mid_up_hold", int'(my_threshold_up), 255);
    pixels(3, 8'd60);
    check("mid_up_hold2", int'(my_threshold_up), 255);
    rise();
    repeat (SUM_W) tick();
    check("m200_up_pre", int'(my_threshold_up), 255);
    tick();
    check("m200_up", int'(my_threshold_up), 200);
    check("m200_down", int'(my_threshold_down), 128);
    check("m200_mean", int'(frame_mean), 60);
    tick();

    mv_ref = mv_cnt;
    rise();
    check("zero_busy", int'(busy), 1);
    tick();
    check("zero_busy_off", int'(busy), 0);
    repeat (3) tick();
    check("zero_pulses", mv_cnt - mv_ref, 0);
    check("zero_mean", int'(frame_mean), 60);

    mv_ref = mv_cnt;
    pixels(8, 8'd80);
    rise();
    repeat (3) tick();
    ycbcr_vsync = 1'b0;
    ycbcr_de    = 1'b1;
    luminance   = 8'd200;
    tick();
    ycbcr_de = 1'b0;
    tick();
    ycbcr_vsync = 1'b1;
    tick();
    check("dbl_busy", int'(busy), 1);
    repeat (SUM_W) tick();
    check("dbl_mean", int'(frame_mean), 80);
    check("dbl_pulses", mv_cnt - mv_ref, 1);
    check("dbl_busy_off", int'(busy), 0);

    pixels(4, 8'd20);
    rise();
    wait_update("nxt");
    check("nxt_mean", int'(frame_mean), 20);

    cfg_write(2'd0, 8'd150);
    pixels(4, 8'd90);
    rise();
    repeat (10) tick();
    check("rd_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rd_up", int'(my_threshold_up), 255);
    check("rd_down", int'(my_threshold_down), 128);
    check("rd_mean", int'(frame_mean), 0);
    check("rd_mv", int'(mean_valid), 0);
    check("rd_busy_off", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    repeat (SUM_W + 4) tick();
    check("rd_mean_after", int'(frame_mean), 0);
    check("rd_up_after", int'(my_threshold_up), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/threshold_ctrl.md
THRESHOLD_CTRL -- requirements
Module: threshold_ctrl

Interface
REQ-001 SHALL have parameter SUM_W, default 27, the luminance-sum accumulator width (supports up to 2^19 pixels/frame).
REQ-002 SHALL have parameter CNT_W, default 19, the pixel-count accumulator width.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ycbcr_vsync  input  1  frame sync, high during vertical blanking.
REQ-006 SHALL have port ycbcr_de  input  1  active-pixel qualifier.
REQ-007 SHALL have port luminance  input  8  Y value of the current pixel.
REQ-008 SHALL have port cfg_wr  input  1  single-cycle config write strobe.
REQ-009 SHALL have port cfg_addr  input  2  register select: 0=man_up, 1=man_down, 2=margin, 3=mode (bit0: 1=auto).
REQ-010 SHALL have port cfg_wdata  input  8  config write data.
REQ-011 SHALL have port my_threshold_up  output  8  upper threshold driven to the binarizer.
REQ-012 SHALL have port my_threshold_down  output  8  lower threshold driven to the binarizer.
REQ-013 SHALL have port frame_mean  output  8  mean luminance of the last completed frame.
REQ-014 SHALL have port mean_valid  output  1  one-cycle pulse when frame_mean updates.
REQ-015 SHALL have port busy  output  1  high while FSM is not in IDLE.

Function
REQ-016 SHALL accumulate, on every cycle with ycbcr_de=1, sum += luminance and cnt += 1; sum and cnt saturate at all-ones.
REQ-017 SHALL detect frame end as a rising edge of ycbcr_vsync (registered previous value 0, current 1).
REQ-018 SHALL, at frame end, latch sum/cnt into divider operands and clear sum/cnt in the same cycle; a pixel with de=1 in that cycle starts the new frame's sum/cnt.
REQ-019 SHALL implement FSM states IDLE, DIVIDE, UPDATE; IDLE->DIVIDE at frame end when latched cnt != 0; IDLE->UPDATE at frame end when cnt == 0.
REQ-020 SHALL compute quotient = floor(sum/cnt) by restoring division, one quotient bit per cycle, exactly SUM_W cycles in DIVIDE, then -> UPDATE.
REQ-021 SHALL saturate quotient to 255 when it exceeds 8 bits; cnt==0 SHALL leave frame_mean unchanged and suppress mean_valid.
REQ-022 SHALL, in UPDATE (one cycle, then -> IDLE), load frame_mean, pulse mean_valid, and apply pending thresholds to outputs.
REQ-023 SHALL, in auto mode, set up = min(mean+margin, 255), down = max(mean-margin, 0), computed at 9-bit width.
REQ-024 SHALL, in manual mode, set up = man_up, down = man_down as shadowed at frame end.
REQ-025 SHALL shadow all cfg registers at frame end; cfg writes take effect only at the UPDATE following the next frame end, never mid-frame.
REQ-026 SHALL ignore a frame end arriving while in DIVIDE or UPDATE (that frame's stats discarded, accumulators still cleared); blanking of at least SUM_W+4 cycles is a system requirement.
REQ-027 SHALL accept a cfg write on the same cycle as a frame end; the new value is included in that shadow.
REQ-028 SHALL keep my_threshold_up/down constant except in UPDATE.

Reset
REQ-029 SHALL on reset set my_threshold_up=255, my_threshold_down=128, frame_mean=0, mean_valid=0, busy=0, FSM=IDLE, sum=cnt=0.
REQ-030 SHALL on reset set man_up=255, man_down=128, margin=40, mode=0 (manual); reset mid-DIVIDE aborts with no output update.

Verification
REQ-031 SHALL verify: auto mode, 64-pixel frame all luminance=100, margin=40 -> after vsync rise + SUM_W+1 cycles, frame_mean=100, up=140, down=60, one mean_valid pulse.
REQ-032 SHALL verify: auto, frame all 250, margin=40 -> up=255 (saturate), down=210; frame all 10 -> down=0, up=50.
REQ-033 SHALL verify: manual, write man_up=200 mid-frame -> outputs unchanged until UPDATE after next vsync rise, then up=200.
REQ-034 SHALL verify: frame with zero de cycles -> no mean_valid, frame_mean retains prior value, busy high exactly one cycle.
REQ-035 SHALL verify: second vsync rise during DIVIDE -> ignored, single mean_valid, next frame accumulates from zero.
REQ-036 SHALL verify: rst_n low mid-DIVIDE -> all outputs return to reset values asynchronously, busy=0.
